// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI event types, status constants and data-count helper
package midi_pkg;
  typedef enum logic [2:0] {
    NOTE_OFF   = 3'd0,
    NOTE_ON    = 3'd1,
    POLY_AT    = 3'd2,
    CC         = 3'd3,
    PROG       = 3'd4,
    CH_PRESS   = 3'd5,
    PITCH_BEND = 3'd6
  } ev_type_e;
  localparam logic [7:0] ST_SYSEX     = 8'hF0;
  localparam logic [7:0] ST_EOX       = 8'hF7;
  localparam logic [7:0] ST_RT_FIRST  = 8'hF8;
  localparam logic [7:0] ST_SYS_RESET = 8'hFF;
  typedef struct packed {
    ev_type_e   ev_type;
    logic [3:0] channel;
    logic [6:0] data1;
    logic [6:0] data2;
  } midi_event_t;
  function automatic logic [1:0] data_count(input logic [3:0] nib);
    return (nib == 4'hC || nib == 4'hD) ? 2'd1 : 2'd2;
  endfunction
endpackage

// File: rtl/midi_event_fifo.sv
// midi_event_fifo: first-word-fallthrough FIFO; a push into a full FIFO succeeds only alongside a pop
module midi_event_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata = mem_q[rd_q];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata;
endmodule

// File: rtl/midi_event_parser.sv
// midi_event_parser: MIDI byte stream to channel-voice events with running status, SysEx skip and real-time passthrough
module midi_event_parser
  import midi_pkg::*;
#(
  parameter int FIFO_DEPTH          = 4,
  parameter int NOTE_ON_ZERO_IS_OFF = 1,
  parameter int RUNNING_STATUS      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic [15:0] channel_mask,
  input  logic        overflow_clr,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [2:0]  ev_type,
  output logic [3:0]  ev_channel,
  output logic [6:0]  ev_data1,
  output logic [6:0]  ev_data2,
  output logic        rt_valid,
  output logic [7:0]  rt_byte,
  output logic        sys_reset,
  output logic        overflow
);
  localparam logic [1:0] NO_STATUS = 2'd0;
  localparam logic [1:0] WAIT_D1   = 2'd1;
  localparam logic [1:0] WAIT_D2   = 2'd2;
  localparam logic [1:0] SYSEX     = 2'd3;
  logic [1:0] state_q, state_d;
  logic [3:0] status_q, status_d, chan_q, chan_d;
  logic [6:0] d1_q, d1_d;
  logic [7:0] rt_byte_q, rt_byte_d;
  logic rt_valid_q, rt_valid_d, sys_reset_q, sys_reset_d, overflow_q, overflow_d;
  logic is_rt, is_status, is_data, complete, push, pop, fifo_full, fifo_empty;
  logic [20:0] fifo_rdata;
  midi_event_t ev, head;
  always_comb begin
    is_rt = in_valid && in_data >= ST_RT_FIRST;
    is_status = in_valid && in_data[7] && !is_rt;
    is_data = in_valid && !in_data[7];
    complete = is_data && ((state_q == WAIT_D1 && data_count(status_q) == 2'd1) || state_q == WAIT_D2);
    ev.channel = chan_q;
    ev.data1 = (state_q == WAIT_D2) ? d1_q : in_data[6:0];
    ev.data2 = (state_q == WAIT_D2) ? in_data[6:0] : 7'd0;
    ev.ev_type = (NOTE_ON_ZERO_IS_OFF != 0 && status_q[2:0] == NOTE_ON && ev.data2 == 7'd0)
                 ? NOTE_OFF : ev_type_e'(status_q[2:0]);
    push = complete && channel_mask[chan_q];
    pop = !fifo_empty && ev_ready;
    // system common bytes (0xF0..0xF7) all cancel running status; only 0xF0 enters SysEx
    state_d = is_status ? (in_data < ST_SYSEX ? WAIT_D1 : in_data == ST_SYSEX ? SYSEX : NO_STATUS)
            : complete ? (RUNNING_STATUS != 0 ? WAIT_D1 : NO_STATUS)
            : (is_data && state_q == WAIT_D1) ? WAIT_D2 : state_q;
    status_d = is_status ? (in_data < ST_SYSEX ? in_data[7:4] : 4'd0) : status_q;
    chan_d = is_status ? (in_data < ST_SYSEX ? in_data[3:0] : 4'd0) : chan_q;
    d1_d = (is_data && state_q == WAIT_D1) ? in_data[6:0] : d1_q;
    rt_valid_d = is_rt;
    rt_byte_d = is_rt ? in_data : rt_byte_q;
    sys_reset_d = in_valid && in_data == ST_SYS_RESET;
    overflow_d = (overflow_q && !overflow_clr) || (push && fifo_full && !pop);
    head = fifo_empty ? '0 : midi_event_t'(fifo_rdata);
    ev_valid = !fifo_empty;
    ev_type = head.ev_type;
    ev_channel = head.channel;
    ev_data1 = head.data1;
    ev_data2 = head.data2;
    rt_valid = rt_valid_q;
    rt_byte = rt_byte_q;
    sys_reset = sys_reset_q;
    overflow = overflow_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NO_STATUS;
      status_q <= '0;
      chan_q <= '0;
      d1_q <= '0;
      rt_valid_q <= 1'b0;
      rt_byte_q <= '0;
      sys_reset_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      chan_q <= chan_d;
      d1_q <= d1_d;
      rt_valid_q <= rt_valid_d;
      rt_byte_q <= rt_byte_d;
      sys_reset_q <= sys_reset_d;
      overflow_q <= overflow_d;
    end
  end
  midi_event_fifo #(.WIDTH(21), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata(ev),
    .rdata(fifo_rdata),
    .full(fifo_full),
    .empty(fifo_empty)
  );
endmodule

// File: tb/tb_midi_event_parser.sv
// tb_midi_event_parser: directed test-plan steps then random byte streams against a queue-based reference model
module tb_midi_event_parser;
  logic clk = 0, rst = 1, in_valid = 0, overflow_clr = 0, ev_ready = 0;
  logic [7:0] in_data = 0;
  logic [15:0] channel_mask = 16'hFFFF;
  logic ev_valid, rt_valid, sys_reset, overflow;
  logic [2:0] ev_type;
  logic [3:0] ev_channel;
  logic [6:0] ev_data1, ev_data2;
  logic [7:0] rt_byte;
  int checks = 0, errors = 0;
  typedef struct {int t; int ch; int d1; int d2;} ev_t;
  ev_t exp_q[$];
  int dq[$];
  int rs, m_rtb;
  bit m_ov, m_rt, m_sr;

  midi_event_parser #(.FIFO_DEPTH(4), .NOTE_ON_ZERO_IS_OFF(1), .RUNNING_STATUS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .channel_mask(channel_mask), .overflow_clr(overflow_clr),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type),
    .ev_channel(ev_channel), .ev_data1(ev_data1), .ev_data2(ev_data2),
    .rt_valid(rt_valid), .rt_byte(rt_byte), .sys_reset(sys_reset), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    dq.delete();
    rs = 0; m_rtb = 0; m_ov = 0; m_rt = 0; m_sr = 0;
  endtask

  // reference: a status byte plus the list of data bytes collected so far
  task automatic model_step(input logic v, input logic [7:0] b, input logic rdy);
    int need;
    bit have, drop, pop;
    ev_t e;
    have = 0; drop = 0;
    pop = exp_q.size() != 0 && rdy;
    m_rt = 0; m_sr = 0;
    if (v) begin
      if (b >= 8'hF8) begin
        m_rt = 1; m_rtb = b; m_sr = (b == 8'hFF);
      end else if (b >= 8'hF0) begin
        rs = 0; dq.delete();
      end else if (b[7]) begin
        rs = b; dq.delete();
      end else if (rs != 0) begin
        dq.push_back(int'(b));
        need = ((rs >> 4) == 12 || (rs >> 4) == 13) ? 1 : 2;
        if (dq.size() == need) begin
          e.t = (rs >> 4) - 8; e.ch = rs % 16; e.d1 = dq[0]; e.d2 = (need == 2) ? dq[1] : 0;
          if (e.t == 1 && e.d2 == 0) e.t = 0;
          have = channel_mask[e.ch];
          dq.delete();
        end
      end
    end
    if (pop) void'(exp_q.pop_front());
    if (have) begin
      if (exp_q.size() < 4) exp_q.push_back(e);
      else drop = 1;
    end
    m_ov = (m_ov && !overflow_clr) || drop;
  endtask

  task automatic check_model();
    chk("ev_valid", ev_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("ev_type", ev_type, exp_q[0].t);
      chk("ev_channel", ev_channel, exp_q[0].ch);
      chk("ev_data1", ev_data1, exp_q[0].d1);
      chk("ev_data2", ev_data2, exp_q[0].d2);
    end
    chk("rt_valid", rt_valid, m_rt);
    chk("rt_byte", rt_byte, m_rtb);
    chk("sys_reset", sys_reset, m_sr);
    chk("overflow", overflow, m_ov);
  endtask

  task automatic cyc(input logic v, input logic [7:0] b, input logic rdy);
    check_model();
    in_valid = v; in_data = b; ev_ready = rdy;
    model_step(v, b, rdy);
    @(negedge clk);
    overflow_clr = 0;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; ev_ready = 0; overflow_clr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic head(input string tag, input int t, input int ch, input int d1, input int d2);
    chk({tag, "_valid"}, ev_valid, 1);
    chk({tag, "_type"}, ev_type, t);
    chk({tag, "_ch"}, ev_channel, ch);
    chk({tag, "_d1"}, ev_data1, d1);
    chk({tag, "_d2"}, ev_data2, d2);
  endtask

  initial begin
    do_reset();
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_rt_valid", rt_valid, 0);
    chk("rst_sys_reset", sys_reset, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rt_byte", rt_byte, 0);
    chk("rst_ev_fields", {ev_type, ev_channel, ev_data1, ev_data2}, 0);

    cyc(1, 8'h93, 0); cyc(1, 8'h3C, 0);
    chk("t1_not_yet", ev_valid, 0);
    cyc(1, 8'h64, 0);
    head("t1", 1, 3, 8'h3C, 8'h64);
    cyc(0, 0, 1);

    cyc(1, 8'h90, 0); cyc(1, 8'h40, 0); cyc(1, 8'h7F, 0); cyc(1, 8'h41, 0); cyc(1, 8'h00, 0);
    head("t2a", 1, 0, 8'h40, 8'h7F);
    cyc(0, 0, 1);
    head("t2b", 0, 0, 8'h41, 0);
    cyc(0, 0, 1);

    cyc(1, 8'hE5, 0); cyc(1, 8'h00, 0); cyc(1, 8'hF8, 0);
    chk("t3_rt_valid", rt_valid, 1);
    chk("t3_rt_byte", rt_byte, 8'hF8);
    cyc(1, 8'h40, 0);
    head("t3", 6, 5, 0, 8'h40);
    cyc(0, 0, 1);

    cyc(1, 8'hF0, 0); cyc(1, 8'h7E, 0); cyc(1, 8'h01, 0); cyc(1, 8'hFF, 0);
    chk("t4_sys_reset", sys_reset, 1);
    chk("t4_rt_byte", rt_byte, 8'hFF);
    cyc(1, 8'hF7, 0); cyc(1, 8'h45, 0);
    chk("t4_orphan", ev_valid, 0);
    cyc(1, 8'hC2, 0); cyc(1, 8'h07, 0);
    head("t4", 4, 2, 7, 0);
    cyc(0, 0, 1);

    channel_mask = 16'h0001;
    cyc(1, 8'h91, 0); cyc(1, 8'h30, 0); cyc(1, 8'h40, 0);
    cyc(1, 8'h80, 0); cyc(1, 8'h30, 0); cyc(1, 8'h00, 0);
    head("t5", 0, 0, 8'h30, 0);
    chk("t5_overflow", overflow, 0);
    cyc(0, 0, 1);
    chk("t5_only_one", ev_valid, 0);
    channel_mask = 16'hFFFF;

    for (int i = 0; i < 5; i++) begin
      cyc(1, 8'h90, 0); cyc(1, 8'(8'h10 + i), 0); cyc(1, 8'h40, 0);
    end
    chk("t6_overflow", overflow, 1);
    head("t6_first", 1, 0, 8'h10, 8'h40);
    overflow_clr = 1;
    cyc(0, 0, 0);
    chk("t6_ovf_clr", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      head("t6_drain", 1, 0, 8'h10 + i, 8'h40);
      cyc(0, 0, 1);
    end
    chk("t6_empty", ev_valid, 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'h90, 0); cyc(1, 8'(8'h10 + i), 0); cyc(1, 8'h40, 0);
    end
    cyc(1, 8'h90, 0); cyc(1, 8'h20, 0); cyc(1, 8'h40, 1);
    chk("t6b_full_pushpop_ovf", overflow, 0);
    head("t6b_head", 1, 0, 8'h11, 8'h40);
    repeat (4) cyc(0, 0, 1);
    chk("t6b_empty", ev_valid, 0);

    cyc(1, 8'h90, 0); cyc(1, 8'h40, 0);
    do_reset();
    cyc(1, 8'h41, 0); cyc(1, 8'h42, 0);
    chk("t7_after_rst", ev_valid, 0);
    cyc(1, 8'h90, 0); cyc(1, 8'h41, 0); cyc(1, 8'h42, 0);
    head("t7", 1, 0, 8'h41, 8'h42);
    cyc(0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      logic v, rdy;
      if (i % 250 == 0) channel_mask = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'hFFFF;
      overflow_clr = $urandom_range(0, 49) == 0;
      r = $urandom_range(0, 99);
      v = 1;
      if (r < 55) b = 8'($urandom_range(0, 127));
      else if (r < 75) b = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 80) b = $urandom_range(0, 1) ? 8'hF0 : 8'hF7;
      else if (r < 84) b = 8'($urandom_range(8'hF1, 8'hF6));
      else if (r < 92) b = 8'($urandom_range(8'hF8, 8'hFF));
      else begin b = 8'($urandom); v = 0; end
      rdy = ((i / 150) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      cyc(v, b, rdy);
    end
    repeat (8) cyc(0, 0, 1);
    check_model();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/midi_event_parser.md
# midi_event_parser

Parametrised MIDI byte-stream parser that turns UART-delivered bytes into complete channel-voice events, buffered in a small FIFO with valid/ready output. Sits between the MIDI UART receiver and the voice allocator / synth control. Generalises the earlier note-only controller:
- all seven channel-voice message types
- running status
- per-channel filtering
- SysEx skipping
- interleaved system real-time bytes
- back-pressure via FIFO

## Interface
Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16
- NOTE_ON_ZERO_IS_OFF, 1, when 1 a Note On with velocity 0 is emitted as NOTE_OFF
- RUNNING_STATUS, 1, when 0 data bytes without a fresh status byte are discarded

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  one-cycle strobe, in_data holds a received byte
- in_data  in  8  received MIDI byte
- channel_mask  in  16  bit n=1 enables channel n; sampled when the event completes
- overflow_clr  in  1  clears overflow
- ev_valid  out  1  FIFO non-empty
- ev_ready  in  1  consumer accepts head event when ev_valid&ev_ready
- ev_type  out  3  event type, see package
- ev_channel  out  4  MIDI channel 0..15
- ev_data1  out  7  note / controller / program / pressure / bend LSB
- ev_data2  out  7  velocity / value / bend MSB; 0 for one-data-byte messages
- rt_valid  out  1  one-cycle pulse per real-time byte 0xF8..0xFF
- rt_byte  out  8  the real-time byte, held until next rt_valid
- sys_reset  out  1  one-cycle pulse on 0xFF, concurrent with rt_valid
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Parser states: NO_STATUS, WAIT_D1, WAIT_D2, SYSEX.
- Registers: running status (status nibble, channel), latched data1.
- Status 0x80–0xEF: latch type and channel, go to WAIT_D1, discard any partial message.
  - Data count is 2 for 0x8,0x9,0xA,0xB,0xE and 1 for 0xC,0xD.
- Data byte (bit7=0):
  - NO_STATUS: discarded.
  - WAIT_D1: latch data1. Go to WAIT_D2 for two-byte types; otherwise complete.
  - WAIT_D2: complete.
  - On completion, go to WAIT_D1 if RUNNING_STATUS=1, else NO_STATUS.
  - SYSEX: discarded.
- 0xF0: enter SYSEX, clear running status.
- 0xF7: leave SYSEX to NO_STATUS.
- 0xF1–0xF6: go to NO_STATUS, clear running status. Their data bytes are discarded as orphan data.
- 0xF8–0xFF: rt_valid and rt_byte asserted next cycle. Parser state and partial message are untouched, including inside SYSEX. 0xFF additionally pulses sys_reset; parser state is not reset by it.
- Completion: build the event {type, channel, data1, data2}.
  - Pitch bend: data1 = LSB, data2 = MSB.
  - Note On with velocity 0 becomes NOTE_OFF when NOTE_ON_ZERO_IS_OFF=1.
  - Push only if channel_mask[channel]=1; masked events are parsed and dropped silently, with no overflow.
- FIFO:
  - First-word-fallthrough; ev_* show the head entry while ev_valid=1.
  - Push when full: dropped and overflow set, unless a pop occurs in the same cycle, in which case both succeed.
  - Push and pop on a non-full, non-empty FIFO: count unchanged.
- overflow_clr and a new overflow in the same cycle: overflow stays 1.
- Reset values:
  - State NO_STATUS, running status cleared, FIFO empty.
  - ev_valid, rt_valid, sys_reset, overflow all 0.
  - rt_byte, ev_type, ev_channel, ev_data1, ev_data2 all 0.

## Timing
- Latency: ev_valid rises 1 cycle after the in_valid of the completing data byte, when the FIFO is empty.
- rt_valid and sys_reset rise 1 cycle after the in_valid of the real-time byte and last 1 cycle.
- in_valid can be asserted every cycle. The block never stalls input; full-FIFO loss shows only via overflow.
- ev_ready is ignored while ev_valid=0. The head entry advances the cycle after a handshake.
- rst mid-message: the partial message is lost, FIFO contents are discarded, and the next data byte is discarded until a status byte arrives.

## Structure
- Package midi_pkg holds:
  - Event type enum: NOTE_OFF=0, NOTE_ON=1, POLY_AT=2, CC=3, PROG=4, CH_PRESS=5, PITCH_BEND=6.
  - Status-byte constants: 0xF0, 0xF7, 0xF8, 0xFF.
  - Function mapping status nibble to data-byte count.
  - Packed event struct: 3+4+7+7 = 21 bits.
- One sub-module: midi_event_fifo, a parametrised synchronous FIFO (WIDTH=21, DEPTH=FIFO_DEPTH) with full/empty and simultaneous push/pop support.

## Test plan
- 0x93,0x3C,0x64 → one event NOTE_ON ch3 d1=0x3C d2=0x64; ev_valid 1 cycle after the last byte.
- 0x90,0x40,0x7F,0x41,0x00 with NOTE_ON_ZERO_IS_OFF=1 → two events:
  - NOTE_ON ch0 0x40/0x7F
  - NOTE_OFF ch0 0x41/0x00 (running status)
- 0xE5,0x00,0xF8,0x40 → rt_valid with rt_byte=0xF8 mid-message, then PITCH_BEND ch5 d1=0x00 d2=0x40.
- 0xF0,0x7E,0x01,0xFF,0xF7,0x45,0xC2,0x07 → sys_reset pulse during SysEx, 0x45 discarded, then PROG ch2 d1=0x07 d2=0.
- channel_mask=0x0001, send 0x91,0x30,0x40 then 0x80,0x30,0x00 → only NOTE_OFF ch0 emitted; overflow stays 0.
- ev_ready=0, FIFO_DEPTH=4, send 5 complete notes → 4 buffered, overflow=1. Assert overflow_clr → 0. Drain yields the first 4 in order.
